// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-field encodings common to every ALU slice
// and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLT = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_adder_flags.sv
// Combinational WIDTH-bit adder producing the wrapped sum, the unsigned
// carry out of the sign bit and two's-complement signed overflow.
module alu_adder_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  // Overflow only when both operands share a sign the sum does not.
  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
    overflow     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule : alu_adder_flags

// File: rtl/alu_add_logic_unit.sv
// Registered ADD/AND/OR slice of the execute-stage ALU; result and status
// flags are flopped once so they feed the EX/MEM boundary directly.
module alu_add_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             out_valid,
  output logic [WIDTH-1:0] busOut,
  output logic             zero,
  output logic             overflow,
  output logic             carryout,
  output logic             negative
);

  logic [WIDTH-1:0] add_sum_s;
  logic             add_carry_s;
  logic             add_ovf_s;

  logic [WIDTH-1:0] result_s;
  logic             res_ovf_s;
  logic             res_carry_s;

  logic [WIDTH-1:0] busout_d,   busout_q;
  logic             zero_d,     zero_q;
  logic             overflow_d, overflow_q;
  logic             carryout_d, carryout_q;
  logic             negative_d, negative_q;
  logic             out_valid_d, out_valid_q;

  alu_adder_flags #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a       (busA),
    .b       (busB),
    .sum     (add_sum_s),
    .carry   (add_carry_s),
    .overflow(add_ovf_s)
  );

  // Opcode mux; codes owned by other ALU slices collapse to a clean NOP.
  always_comb begin
    result_s    = '0;
    res_ovf_s   = 1'b0;
    res_carry_s = 1'b0;
    case (alu_op_e'(control))
      ALU_ADD: begin
        result_s    = add_sum_s;
        res_ovf_s   = add_ovf_s;
        res_carry_s = add_carry_s;
      end
      ALU_AND: result_s = busA & busB;
      ALU_OR:  result_s = busA | busB;
      default: begin
        result_s    = '0;
        res_ovf_s   = 1'b0;
        res_carry_s = 1'b0;
      end
    endcase
  end

  // Next-state: capture on in_valid, otherwise hold result and flags.
  always_comb begin
    busout_d    = busout_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    carryout_d  = carryout_q;
    negative_d  = negative_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      busout_d    = result_s;
      zero_d      = (result_s == {WIDTH{1'b0}});
      overflow_d  = res_ovf_s;
      carryout_d  = res_carry_s;
      negative_d  = result_s[WIDTH-1];
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset presents a zero result with zero flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busout_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      carryout_q  <= 1'b0;
      negative_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      busout_q    <= busout_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carryout_q  <= carryout_d;
      negative_q  <= negative_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busOut    = busout_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carryout  = carryout_q;
  assign negative  = negative_q;
  assign out_valid = out_valid_q;

endmodule : alu_add_logic_unit

// File: tb/tb_alu_add_logic_unit.sv
// Scoreboard bench for alu_add_logic_unit: a reference model pushes the
// expected registered outputs per driven cycle, popped one edge later.
module tb_alu_add_logic_unit;

  localparam int W = 32;

  typedef struct packed {
    logic         v;
    logic [W-1:0] bus;
    logic         z;
    logic         o;
    logic         c;
    logic         n;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   control;
  logic [W-1:0] busA;
  logic [W-1:0] busB;
  logic         out_valid;
  logic [W-1:0] busOut;
  logic         zero;
  logic         overflow;
  logic         carryout;
  logic         negative;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t model;

  localparam exp_t RESET_STATE = '{v: 1'b0, bus: 32'h0, z: 1'b1, o: 1'b0, c: 1'b0, n: 1'b0};

  alu_add_logic_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .control  (control),
    .busA     (busA),
    .busB     (busB),
    .out_valid(out_valid),
    .busOut   (busOut),
    .zero     (zero),
    .overflow (overflow),
    .carryout (carryout),
    .negative (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_next(input exp_t prev, input logic vld, input logic [2:0] ctl,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t     e;
    logic [W:0] s;
    e = prev;
    e.v = vld;
    if (vld) begin
      e.o = 1'b0;
      e.c = 1'b0;
      case (ctl)
        3'b001: begin
          s     = {1'b0, a} + {1'b0, b};
          e.bus = s[W-1:0];
          e.c   = s[W];
          e.o   = (a[W-1] & b[W-1] & ~s[W-1]) | (~a[W-1] & ~b[W-1] & s[W-1]);
        end
        3'b011:  e.bus = a & b;
        3'b100:  e.bus = a | b;
        default: e.bus = 32'h0;
      endcase
      e.z = (e.bus == 32'h0);
      e.n = e.bus[W-1];
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk_eq({tag, ".out_valid"}, {63'b0, out_valid}, {63'b0, e.v});
    chk_eq({tag, ".busOut"},    {32'b0, busOut},    {32'b0, e.bus});
    chk_eq({tag, ".zero"},      {63'b0, zero},      {63'b0, e.z});
    chk_eq({tag, ".overflow"},  {63'b0, overflow},  {63'b0, e.o});
    chk_eq({tag, ".carryout"},  {63'b0, carryout},  {63'b0, e.c});
    chk_eq({tag, ".negative"},  {63'b0, negative},  {63'b0, e.n});
    chk_eq({tag, ".noX"}, {63'b0, $isunknown({out_valid, busOut, zero, overflow, carryout, negative})}, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic vld, input logic [2:0] ctl,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t got;
    @(negedge clk);
    in_valid = vld;
    control  = ctl;
    busA     = a;
    busB     = b;
    model    = model_next(model, vld, ctl, a, b);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      check_outputs(tag, got);
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    model = RESET_STATE;
    check_outputs(tag, model);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    control  = 3'b000;
    busA     = 32'h0;
    busB     = 32'h0;
    model    = RESET_STATE;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por", model);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_pre", 1'b1, 3'b001, 32'h8000_0000, 32'h8000_0001);
    async_reset("async_rst");

    do_op("nop",        1'b1, 3'b000, 32'h0101_0101, 32'h0101_0101);
    do_op("or_hold_pre",1'b1, 3'b100, 32'h0000_00F0, 32'h0000_0F00);
    do_op("hold",       1'b0, 3'b001, 32'h1234_5678, 32'h1111_1111);
    do_op("hold2",      1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("add_ovf",    1'b1, 3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_op("add_wrap",   1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op("add_negovf", 1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000);
    do_op("add_plain",  1'b1, 3'b001, 32'h0000_1234, 32'h0000_4321);
    do_op("and",        1'b1, 3'b011, 32'h0000_0001, 32'hF000_0000);
    do_op("and_neg",    1'b1, 3'b011, 32'hF0F0_F0F0, 32'h8FFF_0000);
    do_op("or",         1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0101_0101);
    do_op("op110",      1'b1, 3'b110, 32'hFFFF_FFFF, 32'h0101_0101);
    do_op("op010",      1'b1, 3'b010, 32'h0000_0005, 32'h0000_0003);
    do_op("op101",      1'b1, 3'b101, 32'hAAAA_AAAA, 32'h5555_5555);
    do_op("op111",      1'b1, 3'b111, 32'h0000_0001, 32'h0000_0001);

    async_reset("async_rst2");
    do_op("post_rst_add", 1'b1, 3'b001, 32'h0000_0002, 32'h0000_0003);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom));
    end

    chk_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_add_logic_unit

// File: doc/alu_add_logic_unit.md
Name: alu_add_logic_unit

Overview:
- Registered 32-bit arithmetic/logic slice of the pipeline CPU execute stage.
- Performs ADD, bitwise AND and bitwise OR on two operand buses.
- Produces a result plus zero/overflow/carryout/negative status flags, registered once so they feed the EX/MEM boundary directly.
- Opcode encoding matches the full ALU control field, so the block drops into the existing control path.

Parameters:
- WIDTH, 32, operand/result width in bits (all flag rules below refer to bit WIDTH-1 as the sign bit).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and control are sampled this cycle.
- control  input  3  operation select: 000 NOP, 001 ADD, 011 AND, 100 OR.
- busA  input  WIDTH  operand A.
- busB  input  WIDTH  operand B.
- out_valid  output  1  busOut and flags hold the result of a sampled operation.
- busOut  output  WIDTH  registered result.
- zero  output  1  registered: busOut == 0.
- overflow  output  1  registered signed overflow.
- carryout  output  1  registered unsigned carry out of bit WIDTH-1.
- negative  output  1  registered busOut[WIDTH-1].

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - busOut = 0, zero = 1, overflow = 0, carryout = 0, negative = 0, out_valid = 0.
- Latency is exactly 1 cycle. On a rising clk edge with in_valid=1:
  - outputs update to the function of the control/busA/busB sampled at that edge;
  - out_valid <= 1.
- Rising clk edge with in_valid=0: out_valid <= 0; busOut and all flags hold their previous values.
- There is no backpressure; a new operation is accepted every cycle.
- ADD: {carry, sum} = busA + busB as a WIDTH+1-bit sum.
  - busOut = sum mod 2^WIDTH (wrap-around).
  - carryout = carry.
  - overflow = 1 iff busA[MSB] == busB[MSB] and sum[MSB] != busA[MSB].
  - negative = sum[MSB]; zero = (sum == 0).
- AND: busOut = busA & busB; zero and negative follow the result; overflow = 0, carryout = 0.
- OR: busOut = busA | busB; zero and negative follow the result; overflow = 0, carryout = 0.
- NOP (000): busOut = 0, zero = 1, overflow = 0, carryout = 0, negative = 0.
- Any other code (010, 101, 110, 111) is handled exactly as NOP. These codes belong to the other ALU slices, and this block must never drive X/Z.
- The next-state logic is purely combinational from the sampled inputs; no state carries between operations.
- Reset deasserting mid-stream: the first edge with rst_n high and in_valid=1 produces a normal result; there is no warm-up cycle.

Decomposition:
- Shared package alu_pkg holds:
  - the 3-bit control encodings NOP/ADD/SUB/AND/OR/XOR/SLT/SLL (000..111, shared with the full ALU);
  - the default data width constant (32).
- Natural sub-module: alu_adder_flags. It is combinational and computes sum, carryout and overflow for WIDTH bits.
- AND/OR, the zero/negative derivation, the opcode mux and the output register live in the top module.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> outputs change immediately to busOut=0, zero=1, other flags 0, out_valid=0.
- NOP, then latency and hold:
  - NOP: busA=busB=0x01010101, control=000 -> after one edge busOut=0x00000000, zero=1, overflow=0, carryout=0, negative=0, out_valid=1.
  - Drop in_valid -> out_valid=0 and busOut holds its previous value.
- ADD signed overflow: busA=0x7FFFFFFF, busB=0x7FFFFFFF, control=001 -> busOut=0xFFFFFFFE, overflow=1, carryout=0, negative=1, zero=0.
- ADD carry/wrap: busA=0xFFFFFFFF, busB=0x00000001, control=001 -> busOut=0x00000000, carryout=1, zero=1, overflow=0, negative=0.
- AND: busA=0x00000001, busB=0xF0000000, control=011 -> busOut=0x00000000, zero=1, negative=0, overflow=0, carryout=0.
- OR, then unsupported code:
  - OR: busA=0xFFFFFFFF, busB=0x01010101, control=100 -> busOut=0xFFFFFFFF, negative=1, zero=0, overflow=0, carryout=0.
  - Follow with control=110 -> busOut=0, zero=1, no X/Z on any output.
